// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/done handshake bundle between a BCD word source and the BCD-to-binary decoder
// Signals:
//   start  request a conversion
//   bcd    sign + 4-digit BCD word
//   busy   conversion in progress
//   done   one-cycle completion pulse
//   n      signed 16-bit result
//   err    malformed-input flag
interface bcd_to_bin_seq_if;
  logic               start;
  logic        [19:0] bcd;
  logic               busy;
  logic               done;
  logic signed [15:0] n;
  logic               err;
  modport master (output start, bcd, input busy, done, n, err);
  modport slave  (input start, bcd, output busy, done, n, err);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential sign-magnitude BCD (sign digit 0/5) to signed 16-bit binary decoder
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   b    slave side of bcd_to_bin_seq_if (start, bcd in; busy, done, n, err out)
module bcd_to_bin_seq (
  input logic clk,
  input logic rst,
  bcd_to_bin_seq_if.slave b
);
  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;
  state_t st, st_n;
  logic [19:0] sh, sh_n;
  logic [13:0] acc, acc_n;
  logic [1:0]  cnt, cnt_n;
  logic        inv, inv_n, busy_n, done_n, err_n, bad;
  logic [15:0] n_n;
  logic [3:0]  dig, sgn;
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      inv    <= 1'b0;
      b.busy <= 1'b0;
      b.done <= 1'b0;
      b.n    <= '0;
      b.err  <= 1'b0;
    end else begin
      st     <= st_n;
      sh     <= sh_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      inv    <= inv_n;
      b.busy <= busy_n;
      b.done <= done_n;
      b.n    <= n_n;
      b.err  <= err_n;
    end
  end
  // The magnitude digits are shifted up through sh[15:12] so the current digit is always in one place
  always_comb begin
    dig    = sh[15:12];
    sgn    = sh[19:16];
    bad    = inv | ~(sgn == 4'd0 | sgn == 4'd5);
    st_n   = st;
    sh_n   = sh;
    acc_n  = acc;
    cnt_n  = cnt;
    inv_n  = inv;
    busy_n = b.busy;
    done_n = 1'b0;
    n_n    = b.n;
    err_n  = b.err;
    case (st)
      IDLE: if (b.start) begin
        sh_n   = b.bcd;
        acc_n  = '0;
        cnt_n  = '0;
        inv_n  = 1'b0;
        busy_n = 1'b1;
        st_n   = CONV;
      end
      CONV: begin
        acc_n = (acc << 3) + (acc << 1) + {10'd0, dig};
        inv_n = inv | (dig > 4'd9);
        sh_n  = {sh[19:16], sh[11:0], 4'h0};
        cnt_n = cnt + 2'd1;
        st_n  = cnt == 2'd3 ? FIN : CONV;
      end
      FIN: begin
        n_n    = bad ? 16'd0 : sgn == 4'd5 ? -{2'b00, acc} : {2'b00, acc};
        err_n  = bad;
        done_n = 1'b1;
        busy_n = 1'b0;
        st_n   = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bcd_to_bin_seq_if b ();
  bcd_to_bin_seq dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [19:0] to_bcd(input int v);
    int m;
    m = v < 0 ? -v : v;
    return {v < 0 ? 4'd5 : 4'd0, 4'(m / 1000), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
  endfunction
  task automatic conv(input string tag, input logic [19:0] w, input logic [15:0] en, input logic ee);
    int k, bc;
    b.start = 1'b1;
    b.bcd   = w;
    step();
    b.start = 1'b0;
    b.bcd   = 20'hFFFFF;
    k  = 0;
    bc = 0;
    while (!b.done && k < 20) begin
      if (b.busy) bc++;
      step();
      k++;
    end
    chk({tag, " latency"}, 16'(k), 16'd5);
    chk({tag, " busy cycles"}, 16'(bc), 16'd5);
    chk({tag, " n"}, b.n, en);
    chk({tag, " err"}, {15'd0, b.err}, {15'd0, ee});
    chk({tag, " busy at done"}, {15'd0, b.busy}, 16'd0);
    step();
    chk({tag, " done width"}, {15'd0, b.done}, 16'd0);
  endtask
  initial begin
    int dn, k;
    logic [15:0] cap;
    rst     = 1'b1;
    b.start = 1'b0;
    b.bcd   = '0;
    step();
    step();
    chk("reset busy", {15'd0, b.busy}, 16'd0);
    chk("reset done", {15'd0, b.done}, 16'd0);
    chk("reset n", b.n, 16'd0);
    chk("reset err", {15'd0, b.err}, 16'd0);
    rst = 1'b0;
    step();
    conv("pos1234", 20'h01234, 16'h04D2, 1'b0);
    conv("neg9999", 20'h59999, 16'hD8F1, 1'b0);
    conv("negzero", 20'h50000, 16'h0000, 1'b0);
    conv("zero", 20'h00000, 16'h0000, 1'b0);
    conv("pos9999", 20'h09999, 16'h270F, 1'b0);
    conv("baddigit", 20'h012A4, 16'h0000, 1'b1);
    conv("badsign", 20'h31234, 16'h0000, 1'b1);
    conv("clear", 20'h00042, 16'h002A, 1'b0);
    conv("badunits", 20'h0000F, 16'h0000, 1'b1);
    conv("neg1", 20'h50001, 16'hFFFF, 1'b0);
    b.start = 1'b1;
    b.bcd   = 20'h00777;
    step();
    b.start = 1'b0;
    step();
    b.start = 1'b1;
    b.bcd   = 20'h00111;
    step();
    b.start = 1'b0;
    b.bcd   = 20'h09999;
    dn  = 0;
    cap = 16'hDEAD;
    for (int i = 0; i < 12; i++) begin
      if (b.done) begin
        dn++;
        cap = b.n;
      end
      step();
    end
    chk("hold done count", 16'(dn), 16'd1);
    chk("hold n", cap, 16'd777);
    chk("hold idle", {15'd0, b.busy}, 16'd0);
    b.start = 1'b1;
    b.bcd   = 20'h01234;
    step();
    b.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst busy", {15'd0, b.busy}, 16'd0);
    chk("rst n", b.n, 16'd0);
    chk("rst done", {15'd0, b.done}, 16'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (b.done) dn++;
      step();
    end
    chk("rst no done", 16'(dn), 16'd0);
    conv("after rst", 20'h00042, 16'h002A, 1'b0);
    rst     = 1'b1;
    b.start = 1'b1;
    b.bcd   = 20'h00555;
    step();
    rst     = 1'b0;
    b.start = 1'b0;
    step();
    chk("rst beats start", {15'd0, b.busy}, 16'd0);
    b.start = 1'b1;
    b.bcd   = 20'h00005;
    k = 0;
    while (!b.done && k < 20) begin
      step();
      k++;
    end
    chk("b2b first n", b.n, 16'd5);
    k = 0;
    step();
    k++;
    while (!b.done && k < 20) begin
      step();
      k++;
    end
    b.start = 1'b0;
    chk("b2b period", 16'(k), 16'd6);
    for (int i = 0; i < 8; i++) step();
    chk("b2b idle", {15'd0, b.busy}, 16'd0);
    for (int v = -9999; v <= 9999; v += 37) conv($sformatf("rt %0d", v), to_bcd(v), 16'(v), 1'b0);
    conv("rt max", to_bcd(9999), 16'd9999, 1'b0);
    conv("rt -1", to_bcd(-1), 16'hFFFF, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
